// File: rtl/rv_dmem_master.sv
// Data-memory bus master: turns single-cycle load/store pulses into one pipelined
// Wishbone access and reports completion, raw load word and bus errors.
module rv_dmem_master #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_data_s_i,
    input  logic [3:0]  dm_data_select_i,
    input  logic        dm_load_i,
    input  logic        dm_store_i,
    output logic        dm_ready_o,
    output logic [31:0] dm_data_l_o,
    output logic        dm_load_done_o,
    output logic        dm_store_done_o,
    output logic        dm_bus_error_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    input  logic        wb_stall_i
);

    localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);
    localparam int TMO_W  = TMO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_EN ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t           state, state_nxt;
    logic [TMO_W-1:0] tmo_cnt;
    logic             accept, complete, fail, timeout_hit, bus_resp;

    // The counter reads k-1 in the k-th cycle with cyc high, so LAST marks the final allowed cycle.
    assign timeout_hit = TMO_EN && (tmo_cnt == TMO_LAST);
    assign bus_resp    = wb_ack_i | wb_err_i;

    assign wb_cyc_o   = (state != IDLE);
    assign wb_stb_o   = (state == REQ);
    assign dm_ready_o = (state == IDLE);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        complete  = 1'b0;
        fail      = 1'b0;
        case (state)
            IDLE: if (dm_load_i || dm_store_i) begin
                accept    = 1'b1;
                state_nxt = REQ;
            end
            REQ: if (!wb_stall_i) begin
                if (bus_resp) complete  = 1'b1;
                else          state_nxt = WAIT;
            end
            WAIT: if (bus_resp) complete = 1'b1;
            default: state_nxt = IDLE;
        endcase
        // err outranks a simultaneous ack; a real response in the last cycle outranks timeout
        if (complete) begin
            fail = wb_err_i;
        end else if (state != IDLE && timeout_hit) begin
            complete = 1'b1;
            fail     = 1'b1;
        end
        if (complete) state_nxt = IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) tmo_cnt <= '0;
        else if (state == IDLE) tmo_cnt <= '0;
        else tmo_cnt <= tmo_cnt + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wb_adr_o        <= '0;
            wb_dat_o        <= '0;
            wb_sel_o        <= '0;
            wb_we_o         <= 1'b0;
            dm_data_l_o     <= '0;
            dm_load_done_o  <= 1'b0;
            dm_store_done_o <= 1'b0;
            dm_bus_error_o  <= 1'b0;
        end else begin
            dm_load_done_o  <= 1'b0;
            dm_store_done_o <= 1'b0;
            dm_bus_error_o  <= 1'b0;
            if (accept) begin
                wb_adr_o <= dm_addr_i;
                wb_dat_o <= dm_data_s_i;
                wb_we_o  <= !dm_load_i;
                wb_sel_o <= dm_load_i ? 4'hF : dm_data_select_i;
            end
            if (complete) begin
                dm_bus_error_o <= fail;
                if (wb_we_o) begin
                    dm_store_done_o <= 1'b1;
                end else begin
                    dm_load_done_o <= 1'b1;
                    dm_data_l_o    <= fail ? 32'h0 : wb_dat_i;
                end
            end
        end
    end

endmodule
